poly_eval_horner_mp: RTL and testbench

Multi-point Horner evaluator for an 8-bit-coefficient polynomial stored in a single-port coefficient memory. It evaluates Q(x) = sum q_i·x^i at N_PTS independent 8-bit points in parallel, over GF(256) or F_251. It is the parametrised successor to the fixed-size evaluation block: runtime length, configurable memory read latency, lane count and field. It sits between the Q/S coefficient memory and the MPC check logic, one coefficient per clock.

---
 rtl/poly_eval_horner_mp.sv | 139 +++++++++++++
 tb/tb_poly_eval_horner_mp.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_horner_mp.sv
// Multi-point Horner evaluator: streams coefficients highest-degree first from a
// single-port memory and updates N_PTS lane accumulators per returned coefficient.
module poly_eval_horner_mp #(
  parameter string FIELD  = "GF256",
  parameter int    M      = 230,
  parameter int    N_PTS  = 4,
  parameter int    RD_LAT = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [8*N_PTS-1:0]       i_r,
  input  logic [$clog2(M+1)-1:0]   i_len,
  output logic [$clog2(M)-1:0]     o_q_addr,
  output logic                     o_q_rd,
  input  logic [7:0]               i_q,
  output logic [8*N_PTS-1:0]       o_eval,
  output logic                     o_busy,
  output logic                     o_done
);
  localparam int LW      = $clog2(M+1);
  localparam int AW      = $clog2(M);
  localparam bit IS_P251 = (FIELD == "P251");

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t            state, state_nxt;
  logic [AW-1:0]     addr, addr_nxt;
  logic [LW-1:0]     len_clamp;
  logic [RD_LAT-1:0] vld_p, vld_nxt;
  logic              start_ok;
  logic              tail_empty;
  logic [7:0]        r_p0   [N_PTS];
  logic [7:0]        acc_p1 [N_PTS];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] p251_mac(input logic [7:0] acc, input logic [7:0] r,
                                          input logic [7:0] q);
    logic [7:0]  q_red;
    logic [15:0] prod;
    logic [7:0]  prod_red;
    logic [8:0]  sum;
    q_red    = (q >= 8'd251) ? q - 8'd251 : q;
    prod     = {8'd0, acc} * {8'd0, r};
    prod_red = 8'(prod % 16'd251);
    sum      = {1'b0, prod_red} + {1'b0, q_red};
    return (sum >= 9'd251) ? 8'(sum - 9'd251) : sum[7:0];
  endfunction

  function automatic logic [7:0] lane_step(input logic [7:0] acc, input logic [7:0] r,
                                           input logic [7:0] q);
    if (IS_P251) return p251_mac(acc, r, q);
    return gf_mul(acc, r) ^ q;
  endfunction

  assign start_ok  = (state == IDLE) && i_start;
  assign len_clamp = (i_len > LW'(M)) ? LW'(M) : i_len;

  always_comb begin
    vld_nxt    = '0;
    vld_nxt[0] = o_q_rd;
    tail_empty = 1'b1;
    for (int i = 1; i < RD_LAT; i++) vld_nxt[i] = vld_p[i-1];
    for (int i = 0; i < RD_LAT - 1; i++) if (vld_p[i]) tail_empty = 1'b0;
  end

  // L=0 runs go through an empty DRAIN so o_done lands one cycle after the start edge
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    case (state)
      IDLE: begin
        if (i_start) begin
          if (len_clamp == '0) begin
            state_nxt = DRAIN;
            addr_nxt  = '0;
          end else begin
            state_nxt = FETCH;
            addr_nxt  = AW'(len_clamp - LW'(1));
          end
        end
      end
      FETCH: begin
        if (addr == '0) state_nxt = DRAIN;
        else            addr_nxt  = addr - AW'(1);
      end
      DRAIN:   if (tail_empty) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      addr  <= '0;
      vld_p <= '0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      vld_p <= vld_nxt;
    end
  end

  // stage p0: points latched at start; stage p1: accumulate returned coefficient
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_PTS; k++) begin
      if (start_ok) r_p0[k] <= i_r[8*k +: 8];
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < N_PTS; k++) begin
      if (i_rst || start_ok)     acc_p1[k] <= '0;
      else if (vld_p[RD_LAT-1])  acc_p1[k] <= lane_step(acc_p1[k], r_p0[k], i_q);
    end
  end

  for (genvar k = 0; k < N_PTS; k++) begin : g_lane
    assign o_eval[8*k +: 8] = acc_p1[k];
  end

  assign o_q_addr = addr;
  assign o_q_rd   = (state == FETCH);
  assign o_busy   = (state == FETCH) || (state == DRAIN);
  assign o_done   = (state == DONE);

endmodule

// File: tb/tb_poly_eval_horner_mp.sv
// Bench for poly_eval_horner_mp: a GF256/RD_LAT=1 and a P251/RD_LAT=3 instance
// share stimulus and memory contents; expected lane results go through per-DUT queues.
module tb_poly_eval_horner_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_start;
  logic [31:0] i_r;
  logic [7:0]  i_len;

  logic [7:0]  g_addr, p_addr;
  logic        g_rd, p_rd, g_busy, p_busy, g_done, p_done;
  logic [7:0]  g_q, p_q, p_d0, p_d1, p_d2;
  logic [31:0] g_eval, p_eval;

  logic [7:0]  mem [0:229];
  logic [31:0] g_expq[$];
  logic [31:0] p_expq[$];
  int          addr_log[$];
  logic [31:0] g_last, p_last;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  poly_eval_horner_mp #(.FIELD("GF256"), .M(230), .N_PTS(4), .RD_LAT(1)) u_g (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_r(i_r), .i_len(i_len),
    .o_q_addr(g_addr), .o_q_rd(g_rd), .i_q(g_q), .o_eval(g_eval),
    .o_busy(g_busy), .o_done(g_done));

  poly_eval_horner_mp #(.FIELD("P251"), .M(230), .N_PTS(4), .RD_LAT(3)) u_p (
    .i_clk(clk), .i_rst(rst), .i_start(i_start), .i_r(i_r), .i_len(i_len),
    .o_q_addr(p_addr), .o_q_rd(p_rd), .i_q(p_q), .o_eval(p_eval),
    .o_busy(p_busy), .o_done(p_done));

  // memory models: 1-cycle and 3-cycle read latency
  always @(posedge clk) begin
    g_q  <= mem[g_addr];
    p_d0 <= mem[p_addr];
    p_d1 <= p_d0;
    p_d2 <= p_d1;
  end
  assign p_q = p_d2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int j = 14; j >= 8; j--) if (p[j]) p = p ^ (15'(9'h11B) << (j - 8));
    return p[7:0];
  endfunction

  function automatic logic [31:0] gf_model(input logic [31:0] r, input int len);
    logic [31:0] v;
    logic [7:0]  s, pw;
    for (int k = 0; k < 4; k++) begin
      s  = 8'h00;
      pw = 8'h01;
      for (int i = 0; i < len; i++) begin
        s  = s ^ gf_ref(mem[i], pw);
        pw = gf_ref(pw, r[8*k +: 8]);
      end
      v[8*k +: 8] = s;
    end
    return v;
  endfunction

  function automatic logic [31:0] p_model(input logic [31:0] r, input int len);
    logic [31:0] v;
    int s, pw, rk, c;
    for (int k = 0; k < 4; k++) begin
      s  = 0;
      pw = 1;
      rk = int'(r[8*k +: 8]);
      for (int i = 0; i < len; i++) begin
        c  = int'(mem[i]) % 251;
        s  = (s + c * pw) % 251;
        pw = (pw * rk) % 251;
      end
      v[8*k +: 8] = 8'(s);
    end
    return v;
  endfunction

  // one run on both DUTs; inj >= 0 pulses a stray i_start (with altered points) mid-run
  task automatic run(input logic [31:0] r, input int len, input int lc, input int inj,
                     input int exp_gl, input int exp_pl);
    int gl, pl, gr, pr;
    bit gd, pd;
    logic [31:0] e;
    g_expq.push_back(gf_model(r, lc));
    p_expq.push_back(p_model(r, lc));
    addr_log.delete();
    @(negedge clk);
    i_r     = r;
    i_len   = 8'(len);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    gd = 0; pd = 0; gr = 0; pr = 0; gl = -1; pl = -1;
    for (int k = 0; k < 600 && !(gd && pd); k++) begin
      if (g_rd) begin gr++; addr_log.push_back(int'(g_addr)); end
      if (p_rd) pr++;
      if (g_done && !gd) begin
        gd = 1; gl = k; g_last = g_eval;
        e = g_expq.pop_front();
        check("g_eval", g_eval, e);
      end
      if (p_done && !pd) begin
        pd = 1; pl = k; p_last = p_eval;
        e = p_expq.pop_front();
        check("p_eval", p_eval, e);
      end
      i_start = (k == inj);
      if (k == inj) i_r = ~r;
      @(negedge clk);
    end
    i_start = 1'b0;
    if (!gd) begin check("g_done_timeout", 32'(gd), 32'd1); void'(g_expq.pop_front()); end
    if (!pd) begin check("p_done_timeout", 32'(pd), 32'd1); void'(p_expq.pop_front()); end
    check("g_latency", 32'(gl), 32'(exp_gl));
    check("p_latency", 32'(pl), 32'(exp_pl));
    check("g_rd_cycles", 32'(gr), 32'(lc));
    check("p_rd_cycles", 32'(pr), 32'(lc));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_r = '0; i_len = '0;
    for (int i = 0; i < 230; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_g_eval", g_eval, 32'h0);
    check("rst_g_ctrl", {g_addr, 5'b0, g_rd, g_busy, g_done}, 32'h0);
    check("rst_p_eval", p_eval, 32'h0);
    check("rst_p_ctrl", {p_addr, 5'b0, p_rd, p_busy, p_done}, 32'h0);
    rst = 1'b0;

    // q = 1 + 2x + 3x^2, lanes r = {2, 0, 1, 0x83}
    mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3;
    run(32'h8301_0002, 3, 3, -1, 4, 6);
    check("gf_lanes012", {8'h00, g_last[23:0]}, 32'h0000_0109);
    check("addr_count", 32'(addr_log.size()), 32'd3);
    for (int i = 0; i < addr_log.size() && i < 3; i++)
      check("addr_seq", 32'(addr_log[i]), 32'(2 - i));
    check("p251_r2", {24'h0, p_last[7:0]}, 32'd17);

    // AES product 0x57 * 0x83
    mem[0] = 8'h00; mem[1] = 8'h57;
    run(32'h8383_8383, 2, 2, -1, 3, 5);
    check("gf_aes", g_last, 32'hC1C1_C1C1);

    mem[0] = 8'd250; mem[1] = 8'd250; mem[2] = 8'd250;
    run(32'h0101_0101, 3, 3, -1, 4, 6);
    check("p251_sat", p_last, 32'hF8F8_F8F8);

    mem[0] = 8'd255;
    run(32'h0000_0000, 1, 1, -1, 2, 4);
    check("p251_q255", p_last, 32'h0404_0404);
    check("gf_q255", g_last, 32'hFFFF_FFFF);

    run(32'h1234_5678, 0, 0, -1, 1, 1);
    check("len0_g", g_last, 32'h0);
    check("len0_p", p_last, 32'h0);

    for (int i = 0; i < 230; i++) mem[i] = 8'($urandom);
    run($urandom, 230, 230, -1, 231, 233);

    run($urandom, 235, 230, -1, 231, 233);
    check("clamp_addr0", (addr_log.size() > 0) ? 32'(addr_log[0]) : 32'hFFFF, 32'd229);

    run($urandom, 20, 20, 5, 21, 23);

    // reset mid-FETCH, then a fresh run
    @(negedge clk);
    i_r = 32'hA5A5_A5A5; i_len = 8'd50; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_g_eval", g_eval, 32'h0);
    check("midrst_g_ctrl", {g_addr, 5'b0, g_rd, g_busy, g_done}, 32'h0);
    check("midrst_p_eval", p_eval, 32'h0);
    check("midrst_p_ctrl", {p_addr, 5'b0, p_rd, p_busy, p_done}, 32'h0);
    rst = 1'b0;
    run($urandom, 10, 10, -1, 11, 13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
